// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, datapath mux encodings and controller state enum shared by the multi-cycle core
package cpu_pkg;
  localparam int OP_RTYPE = 0;
  localparam int OP_J     = 2;
  localparam int OP_SLT   = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_LW    = 35;
  localparam int OP_XORI  = 42;
  localparam int OP_SW    = 43;
  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_OPC   = 2'b11;
  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EXEC   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LW_WB    = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;
endpackage

// File: rtl/mem_wait_watchdog.sv
// mem_wait_watchdog: counts memory wait cycles and flags the cycle that would exceed the limit
module mem_wait_watchdog #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  // en_i already excludes mem_ready, so a ready on the last allowed cycle never expires
  assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: sequences FETCH/DECODE/EXEC/MEM/WB steps of the shared datapath with sticky trap
module multicycle_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int OPCODE_W   = 7,
  parameter int FUNCT_W    = 6,
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                stall,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                trap,
  output logic [3:0]          state_dbg
);
  state_t state_q, state_d;
  logic slt_q, slt_d;
  logic in_wait, advance, wd_exp;
  logic [FUNCT_W:0] unused_sig;
  // zero only qualifies pc_write_cond inside the datapath; funct is decoded by the ALU control
  assign unused_sig = {{FUNCT_W{1'b0}}, zero};
  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign advance = mem_ready & ~stall;
  mem_wait_watchdog #(.LIMIT(WAIT_LIMIT), .CNT_W(WAIT_CNT_W)) u_wd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (~in_wait | advance),
    .en_i      (in_wait & ~stall & ~mem_ready),
    .expired_o (wd_exp)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      slt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slt_q   <= slt_d;
    end
  always_comb begin
    state_d = state_q;
    slt_d   = slt_q;
    if (!stall)
      case (state_q)
        S_IDLE:     state_d = S_FETCH;
        S_FETCH:    state_d = mem_ready ? S_DECODE : wd_exp ? S_TRAP : S_FETCH;
        S_DECODE: begin
          slt_d = opcode == OPCODE_W'(OP_SLT);
          case (opcode)
            OPCODE_W'(OP_RTYPE), OPCODE_W'(OP_SLT): state_d = S_R_EXEC;
            OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):     state_d = S_MEM_ADDR;
            OPCODE_W'(OP_BEQ):                      state_d = S_BRANCH;
            OPCODE_W'(OP_J):                        state_d = S_JUMP;
            OPCODE_W'(OP_XORI):                     state_d = S_I_EXEC;
            default:                                state_d = S_TRAP;
          endcase
        end
        S_R_EXEC:   state_d = S_R_WB;
        S_MEM_ADDR: state_d = (opcode == OPCODE_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   state_d = mem_ready ? S_LW_WB : wd_exp ? S_TRAP : S_MEM_RD;
        S_MEM_WR:   state_d = mem_ready ? S_FETCH : wd_exp ? S_TRAP : S_MEM_WR;
        S_I_EXEC:   state_d = S_I_WB;
        S_R_WB, S_LW_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
        S_TRAP:     state_d = S_TRAP;
        default:    state_d = S_TRAP;
      endcase
  end
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUSRCB_RT;
    alu_op        = ALUOP_FUNCT;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    trap          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUSRCB_FOUR;
        alu_op    = ALUOP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        alu_src_b = ALUSRCB_IMMSH;
        alu_op    = ALUOP_ADD;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = slt_q ? ALUOP_OPC : ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        alu_op    = ALUOP_OPC;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
    // a stalled step must not commit anything; requests stay visible to memory
    pc_write   = pc_write & ~stall;
    ir_write   = ir_write & ~stall;
    reg_write  = reg_write & ~stall;
    mem_write  = mem_write & ~stall;
    instr_done = instr_done & ~stall;
  end
  assign state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed per-cycle vectors checked by a scoreboard monitor
module tb_multicycle_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n, zero, stall, mem_ready;
  logic [6:0] opcode;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic reg_dst, reg_write, mem_to_reg, alu_src_a, instr_done, trap;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
  int total = 0;
  int bad = 0;
  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .stall(stall), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .trap(trap), .state_dbg(state_dbg)
  );
  logic [21:0] outs;
  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, trap, state_dbg};
  localparam logic [21:0] E_IDLE  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0};
  localparam logic [21:0] E_F_R   = {10'b1001010000, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 4'd1};
  localparam logic [21:0] E_F_W   = {10'b0001000000, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 4'd1};
  localparam logic [21:0] E_DEC   = {10'b0000000000, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 4'd2};
  localparam logic [21:0] E_REX   = {10'b0000000001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'd3};
  localparam logic [21:0] E_SLTEX = {10'b0000000001, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 4'd3};
  localparam logic [21:0] E_RWB   = {10'b0000001100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd4};
  localparam logic [21:0] E_RWB_S = {10'b0000001000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'd4};
  localparam logic [21:0] E_MADDR = {10'b0000000001, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 4'd5};
  localparam logic [21:0] E_MRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'd6};
  localparam logic [21:0] E_LWWB  = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd7};
  localparam logic [21:0] E_MWR   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd8};
  localparam logic [21:0] E_BR    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 4'd9};
  localparam logic [21:0] E_J     = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 4'd10};
  localparam logic [21:0] E_IEX   = {10'b0000000001, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0, 4'd11};
  localparam logic [21:0] E_IWB   = {10'b0000000100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd12};
  localparam logic [21:0] E_TRAP  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'd13};
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (outs !== e.v) begin
        bad++;
        $display("FAIL %s: got=%b want=%b", e.tag, outs, e.v);
      end
    end
  task automatic step(input logic r, input logic s, input logic [21:0] e, input string t);
    mem_ready = r;
    stall = s;
    q.push_back('{t, e});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; stall = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, E_IDLE, "rst0");
    step(1, 0, E_IDLE, "rst1");
    rst_n = 1'b1;
    step(1, 0, E_IDLE, "idle");
    opcode = 7'd0;
    step(1, 0, E_F_R, "r_fetch"); step(1, 0, E_DEC, "r_dec");
    step(1, 0, E_REX, "r_exec");  step(1, 0, E_RWB, "r_wb");
    opcode = 7'd3;
    step(1, 0, E_F_R, "slt_fetch"); step(1, 0, E_DEC, "slt_dec");
    step(1, 0, E_SLTEX, "slt_exec"); step(1, 0, E_RWB, "slt_wb");
    opcode = 7'd35;
    step(1, 0, E_F_R, "lw_fetch"); step(1, 0, E_DEC, "lw_dec"); step(1, 0, E_MADDR, "lw_addr");
    for (int i = 0; i < 3; i++) step(0, 0, E_MRD, "lw_wait");
    step(1, 0, E_MRD, "lw_rd"); step(1, 0, E_LWWB, "lw_wb");
    opcode = 7'd43;
    step(1, 0, E_F_R, "sw_fetch"); step(1, 0, E_DEC, "sw_dec");
    step(1, 0, E_MADDR, "sw_addr"); step(1, 0, E_MWR, "sw_wr");
    opcode = 7'd4; zero = 1'b1;
    step(1, 0, E_F_R, "beq1_fetch"); step(1, 0, E_DEC, "beq1_dec"); step(1, 0, E_BR, "beq1_br");
    zero = 1'b0;
    step(1, 0, E_F_R, "beq0_fetch"); step(1, 0, E_DEC, "beq0_dec"); step(1, 0, E_BR, "beq0_br");
    opcode = 7'd2;
    step(1, 0, E_F_R, "j_fetch"); step(1, 0, E_DEC, "j_dec"); step(1, 0, E_J, "j_jump");
    opcode = 7'd42;
    step(1, 0, E_F_R, "xori_fetch"); step(1, 0, E_DEC, "xori_dec");
    step(1, 0, E_IEX, "xori_exec"); step(1, 0, E_IWB, "xori_wb");
    opcode = 7'd0;
    step(1, 1, E_F_W, "stall_fetch"); step(1, 0, E_F_R, "st_fetch");
    step(1, 0, E_DEC, "st_dec"); step(1, 0, E_REX, "st_exec");
    step(1, 1, E_RWB_S, "stall_wb0"); step(1, 1, E_RWB_S, "stall_wb1"); step(1, 0, E_RWB, "st_wb");
    opcode = 7'd2;
    for (int i = 0; i < 14; i++) step(0, 0, E_F_W, "wd_edge_wait");
    step(1, 0, E_F_R, "wd_edge_ready"); step(1, 0, E_DEC, "wd_edge_dec"); step(1, 0, E_J, "wd_edge_j");
    for (int i = 0; i < 15; i++) step(0, 0, E_F_W, "wd_wait");
    total++;
    if (trap !== 1'b1 || state_dbg !== 4'd13) begin
      bad++;
      $display("FAIL wd_expired: trap=%b state=%0d", trap, state_dbg);
    end
    for (int i = 0; i < 3; i++) step(1, 0, E_TRAP, "wd_trap");
    rst_n = 1'b0;
    step(1, 0, E_IDLE, "rst_trap");
    rst_n = 1'b1;
    step(1, 0, E_IDLE, "idle2");
    opcode = 7'd9;
    step(1, 0, E_F_R, "ill_fetch"); step(1, 0, E_DEC, "ill_dec");
    for (int i = 0; i < 20; i++) step(1'(i), 1'(i / 7), E_TRAP, "ill_trap");
    rst_n = 1'b0;
    step(1, 0, E_IDLE, "rst3");
    rst_n = 1'b1;
    step(1, 0, E_IDLE, "idle3");
    opcode = 7'd35;
    step(1, 0, E_F_R, "mlw_fetch"); step(1, 0, E_DEC, "mlw_dec");
    step(1, 0, E_MADDR, "mlw_addr"); step(0, 0, E_MRD, "mlw_wait");
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, E_IDLE, "mlw_rst");
    total++;
    if (outs !== E_IDLE) begin
      bad++;
      $display("FAIL reset_state: got=%b want=%b", outs, E_IDLE);
    end
    rst_n = 1'b1;
    step(1, 0, E_IDLE, "mlw_idle"); step(1, 0, E_F_R, "mlw_refetch");
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
